data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-requester arbiter that shares the single-port 1024x8 data memory between the CPU (requester A) and the program/data loader (requester B). It latches one request at a time, sequences the memory's read/write enables around its one-clock registered read, returns read data with a one-cycle acknowledge pulse, and alternates priority round-robin. It sits between both requesters and the data memory's address, data and enable pins.

## Interface
Parameters:
- ADDR_W, 10, memory address width
- DATA_W, 8, data width
- IN_PORT_ADDR, 10'h3FE, memory-mapped input port address
- OUT_PORT_ADDR, 10'h3FF, memory-mapped output port address

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_a_req, in_b_req  in  1  request from A / B; level, sampled only in IDLE
- in_a_we, in_b_we  in  1  1 = write, 0 = read
- in_a_addr, in_b_addr  in  ADDR_W  access address
- in_a_wdata, in_b_wdata  in  DATA_W  write data
- out_a_ack, out_b_ack  out  1  one-cycle completion pulse
- out_a_rdata, out_b_rdata  out  DATA_W  read result; valid while ack is high, held until next completion for that requester
- out_b_err  out  1  pulses with out_b_ack when B's access was rejected
- out_busy  out  1  high in every state except IDLE
- out_mem_addr  out  ADDR_W  to memory address
- out_mem_write_en, out_mem_read_en  out  1  to memory enables
- out_mem_wdata  out  DATA_W  to memory write data
- in_mem_rdata  in  DATA_W  from memory read data

## Operation
- States: IDLE, ACCESS, HOLD, ACK.
- IDLE: when any req is high, pick the winner, latch its we/addr/wdata plus the winner ID, then go to ACCESS.
- Arbitration: pointer prio (0 = A preferred). If both reqs are high, the preferred requester wins; otherwise the single requester wins. After every grant, prio points at the non-winner.
- ACCESS: drive out_mem_addr = latched addr. For a write, pulse out_mem_write_en; for a read, raise out_mem_read_en. Go to HOLD.
- HOLD: addr held. Read: out_mem_read_en stays high; at the end of HOLD, capture in_mem_rdata into the winner's rdata register. Write: both enables low. Go to ACK.
- ACK: winner's ack = 1; enables low; go to IDLE.
- B reject: a B grant with addr equal to IN_PORT_ADDR or OUT_PORT_ADDR drives no memory enables in any state. out_b_rdata is set to 0x00 and out_b_err = 1 with out_b_ack in ACK.
- A may access the I/O port addresses. The sequence is unchanged and read data is captured from in_mem_rdata as driven on the shared bus.
- Requester fields and req are ignored outside IDLE. Dropping req mid-transaction does not abort; the latched transaction completes and still acks.
- out_mem_addr is 0 and out_mem_wdata is 0 in IDLE.

## Timing
- Reset (rst_n low at a rising edge): state = IDLE, prio = 0. All acks, out_b_err, out_busy and the memory enables = 0. out_mem_addr, out_mem_wdata and both rdata registers = 0.
- Reset mid-transaction aborts immediately with no ack. A write already pulsed in ACCESS is not undone.
- Latency: req high in IDLE at cycle n → ACCESS n+1, HOLD n+2, ACK n+3 (ack high during cycle n+3), IDLE n+4.
- Throughput: one access per 4 cycles. Back-to-back requests from one requester with the other idle are accepted at n+4, n+8, ….
- A req that stays high through ACK is treated as a new request in the following IDLE cycle.
- out_mem_write_en is high for exactly one cycle per write.
- out_mem_read_en is high for exactly two consecutive cycles per read (ACCESS, HOLD).

## Test plan
- Reset then A writes 0x5A to 0x010 → write_en high one cycle at 0x010. Then A reads 0x010 → out_a_ack at n+3 with out_a_rdata = 0x5A. out_b_ack stays 0 throughout.
- A and B both request in the same IDLE cycle after reset → A is served first. A keeps req high, yet B is granted next; grants alternate A, B, A, B over 4 transactions.
- B writes 0x33 to 0x3FF → no memory enable asserted. out_b_ack and out_b_err pulse together at n+3, out_b_rdata = 0x00, and memory at 0x3FF is untouched.
- B reads 0x200 and drops req at n+1 → the transaction still completes. out_b_ack at n+3 with memory contents; arbiter back in IDLE at n+4.
- rst_n low during HOLD of an A read → next cycle: IDLE, no ack, enables 0, out_a_rdata = 0x00, prio = 0.
- Single requester streaming 3 reads from 0x000–0x002 → acks at cycles 3, 7, 11 with the correct data each time. out_busy is low only in cycles 0, 4, 8, 12.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter for the shared single-port data memory.
// One transaction in flight at a time: IDLE -> ACCESS -> HOLD -> ACK -> IDLE.
// Requester A is the CPU and requester B is the loader. Priority alternates
// round-robin. B is refused access to the memory-mapped I/O port addresses.
module data_memory_arbiter #(
  parameter int                 ADDR_W        = 10,
  parameter int                 DATA_W        = 8,
  parameter logic [ADDR_W-1:0]  IN_PORT_ADDR  = 10'h3FE,
  parameter logic [ADDR_W-1:0]  OUT_PORT_ADDR = 10'h3FF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_a_req,
  input  logic              in_b_req,
  input  logic              in_a_we,
  input  logic              in_b_we,
  input  logic [ADDR_W-1:0] in_a_addr,
  input  logic [ADDR_W-1:0] in_b_addr,
  input  logic [DATA_W-1:0] in_a_wdata,
  input  logic [DATA_W-1:0] in_b_wdata,
  output logic              out_a_ack,
  output logic              out_b_ack,
  output logic [DATA_W-1:0] out_a_rdata,
  output logic [DATA_W-1:0] out_b_rdata,
  output logic              out_b_err,
  output logic              out_busy,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_mem_write_en,
  output logic              out_mem_read_en,
  output logic [DATA_W-1:0] out_mem_wdata,
  input  logic [DATA_W-1:0] in_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD, ACK} state_t;

  state_t              state_q, state_d;
  logic                prio_q, prio_d;     // 0: A preferred, 1: B preferred
  logic                win_q, win_d;       // 0: A owns the transaction, 1: B
  logic                we_q, we_d;
  logic                rej_q, rej_d;       // B targeting an I/O port address
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic                b_err_q, b_err_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                busy_q, busy_d;

  logic                grant_b;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_rej;

  // Arbitration of the requests presented during IDLE.
  always_comb begin
    grant_b   = in_b_req && (!in_a_req || prio_q);
    sel_we    = grant_b ? in_b_we    : in_a_we;
    sel_addr  = grant_b ? in_b_addr  : in_a_addr;
    sel_wdata = grant_b ? in_b_wdata : in_a_wdata;
    sel_rej   = grant_b && ((in_b_addr == IN_PORT_ADDR) || (in_b_addr == OUT_PORT_ADDR));
  end

  // Next-state and next-output logic; every output is registered, so each
  // output value is computed for the state being entered.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    win_d     = win_q;
    we_d      = we_q;
    rej_d     = rej_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    mem_we_d  = 1'b0;
    mem_re_d  = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    b_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_a_req || in_b_req) begin
          state_d  = ACCESS;
          win_d    = grant_b;
          prio_d   = !grant_b;
          we_d     = sel_we;
          rej_d    = sel_rej;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          mem_we_d = sel_we && !sel_rej;
          mem_re_d = !sel_we && !sel_rej;
        end
      end
      ACCESS: begin
        // Read enable spans ACCESS and HOLD to cover the registered read.
        state_d  = HOLD;
        mem_re_d = mem_re_q;
      end
      HOLD: begin
        state_d = ACK;
        if (rej_q) begin
          b_rdata_d = '0;
        end else if (!we_q) begin
          if (win_q) b_rdata_d = in_mem_rdata;
          else       a_rdata_d = in_mem_rdata;
        end
        a_ack_d = !win_q;
        b_ack_d = win_q;
        b_err_d = rej_q;
      end
      ACK: begin
        state_d = IDLE;
        addr_d  = '0;
        wdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      rej_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      win_q     <= win_d;
      we_q      <= we_d;
      rej_q     <= rej_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mem_we_q  <= mem_we_d;
      mem_re_q  <= mem_re_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      b_err_q   <= b_err_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign out_a_ack        = a_ack_q;
  assign out_b_ack        = b_ack_q;
  assign out_a_rdata      = a_rdata_q;
  assign out_b_rdata      = b_rdata_q;
  assign out_b_err        = b_err_q;
  assign out_busy         = busy_q;
  assign out_mem_addr     = addr_q;
  assign out_mem_write_en = mem_we_q;
  assign out_mem_read_en  = mem_re_q;
  assign out_mem_wdata    = wdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed cases followed by random
// transactions, each checked cycle by cycle against a transaction-level model.
module tb_data_memory_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, b_req, a_we, b_we;
  logic [9:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ack, b_ack, b_err, busy;
  logic [7:0] a_rdata, b_rdata;
  logic [9:0] mem_addr;
  logic       mem_we, mem_re;
  logic [7:0] mem_wdata, mem_rdata;

  data_memory_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .in_a_req(a_req), .in_b_req(b_req), .in_a_we(a_we), .in_b_we(b_we),
    .in_a_addr(a_addr), .in_b_addr(b_addr),
    .in_a_wdata(a_wdata), .in_b_wdata(b_wdata),
    .out_a_ack(a_ack), .out_b_ack(b_ack),
    .out_a_rdata(a_rdata), .out_b_rdata(b_rdata),
    .out_b_err(b_err), .out_busy(busy),
    .out_mem_addr(mem_addr), .out_mem_write_en(mem_we), .out_mem_read_en(mem_re),
    .out_mem_wdata(mem_wdata), .in_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port 1024x8 memory with registered read, plus a preload port.
  logic [7:0] mem [1024];
  logic       ld_en;
  logic [9:0] ld_addr;
  logic [7:0] ld_data;
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Reference model state.
  logic [7:0] ref_mem [1024];
  logic       prio_m;
  logic [7:0] exp_rd_a, exp_rd_b;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random junk on the requester pins while a transaction is in flight.
  task automatic scramble();
    a_req = 1'($urandom); b_req = 1'($urandom);
    a_we = 1'($urandom);  b_we = 1'($urandom);
    a_addr = 10'($urandom); b_addr = 10'($urandom);
    a_wdata = 8'($urandom); b_wdata = 8'($urandom);
  endtask

  // One arbitration opportunity starting in an IDLE cycle.
  task automatic do_txn(input logic ar, input logic aw, input logic [9:0] aa, input logic [7:0] ad,
                        input logic br, input logic bw, input logic [9:0] ba, input logic [7:0] bd);
    logic       wb, we, rej;
    logic [9:0] addr;
    logic [7:0] wd;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    if (!ar && !br) begin
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_en", 32'({mem_we, mem_re}), 32'd0);
      return;
    end
    wb   = br && (!ar || prio_m);
    prio_m = !wb;
    we   = wb ? bw : aw;
    addr = wb ? ba : aa;
    wd   = wb ? bd : ad;
    rej  = wb && (addr == 10'h3FE || addr == 10'h3FF);
    tick();  // ACCESS
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_addr", 32'(mem_addr), 32'(addr));
    check("acc_we", 32'(mem_we), 32'(we && !rej));
    check("acc_re", 32'(mem_re), 32'(!we && !rej));
    if (we) check("acc_wdata", 32'(mem_wdata), 32'(wd));
    scramble();
    tick();  // HOLD
    check("hold_addr", 32'(mem_addr), 32'(addr));
    check("hold_we", 32'(mem_we), 32'd0);
    check("hold_re", 32'(mem_re), 32'(!we && !rej));
    check("hold_ack", 32'({a_ack, b_ack}), 32'd0);
    if (rej)      exp_rd_b = 8'h00;
    else if (we)  ref_mem[addr] = wd;
    else if (wb)  exp_rd_b = ref_mem[addr];
    else          exp_rd_a = ref_mem[addr];
    scramble();
    tick();  // ACK
    check("ack_a", 32'(a_ack), 32'(!wb));
    check("ack_b", 32'(b_ack), 32'(wb));
    check("ack_err", 32'(b_err), 32'(rej));
    check("ack_rdata_a", 32'(a_rdata), 32'(exp_rd_a));
    check("ack_rdata_b", 32'(b_rdata), 32'(exp_rd_b));
    check("ack_en", 32'({mem_we, mem_re}), 32'd0);
    check("ack_busy", 32'(busy), 32'd1);
    scramble();
    tick();  // back in IDLE
    check("ret_busy", 32'(busy), 32'd0);
    check("ret_addr", 32'(mem_addr), 32'd0);
    check("ret_wdata", 32'(mem_wdata), 32'd0);
    check("ret_ack", 32'({a_ack, b_ack, b_err}), 32'd0);
  endtask

  function automatic logic [9:0] rand_addr();
    if ($urandom_range(0, 5) == 0) return $urandom_range(0, 1) ? 10'h3FE : 10'h3FF;
    return 10'($urandom_range(0, 15));
  endfunction

  initial begin
    int bad;
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    prio_m = 1'b0; exp_rd_a = 8'h00; exp_rd_b = 8'h00;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_en", 32'({mem_we, mem_re}), 32'd0);
    check("rst_ack", 32'({a_ack, b_ack, b_err}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    // Preload memory while reset holds the arbiter idle.
    for (int i = 0; i < 1024; i++) begin
      ld_en = 1'b1; ld_addr = 10'(i); ld_data = 8'($urandom);
      ref_mem[i] = ld_data;
      tick();
    end
    ld_en = 1'b0;
    rst_n = 1'b1;
    tick();

    // A write then read back.
    do_txn(1, 1, 10'h010, 8'h5A, 0, 0, 10'h000, 8'h00);
    do_txn(1, 0, 10'h010, 8'h00, 0, 0, 10'h000, 8'h00);
    // B rejected write to the output port, B read with early req drop.
    do_txn(0, 0, 10'h000, 8'h00, 1, 1, 10'h3FF, 8'h33);
    do_txn(0, 0, 10'h000, 8'h00, 1, 0, 10'h200, 8'h00);
    // A may touch the I/O ports.
    do_txn(1, 1, 10'h3FE, 8'hC3, 0, 0, 10'h000, 8'h00);
    do_txn(1, 0, 10'h3FE, 8'h00, 0, 0, 10'h000, 8'h00);

    // Reset during HOLD of an A read (the grant sets prio to B first).
    a_req = 1; a_we = 0; a_addr = 10'h005; b_req = 0;
    tick();  // ACCESS
    a_req = 0;
    tick();  // HOLD
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_en", 32'({mem_we, mem_re}), 32'd0);
    check("mid_rst_ack", 32'({a_ack, b_ack}), 32'd0);
    check("mid_rst_rdata_a", 32'(a_rdata), 32'd0);
    prio_m = 1'b0; exp_rd_a = 8'h00; exp_rd_b = 8'h00;
    tick();
    check("post_rst_ack", 32'({a_ack, b_ack}), 32'd0);

    // Both requesting: grants alternate A, B, A, B.
    for (int i = 0; i < 4; i++)
      do_txn(1, 0, 10'(i), 8'h00, 1, 0, 10'(i + 8), 8'h00);

    // Random traffic.
    for (int i = 0; i < 250; i++)
      do_txn(($urandom_range(0, 3) != 0), 1'($urandom), rand_addr(), 8'($urandom),
             ($urandom_range(0, 3) != 0), 1'($urandom), rand_addr(), 8'($urandom));

    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    check("mem_contents", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
